txuart_arbiter: RTL and testbench

//  Shares one txuart transmitter between NREQ message sources. Grants are

---
 rtl/txuart_arbiter.sv | 126 ++++++++++++
 tb/tb_txuart_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/txuart_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : txuart_arbiter
// Purpose : round-robin owner of a single txuart, granting whole messages so
//           bytes from different sources never interleave on the serial line.
// Revision: 1.0  initial release
// ============================================================================
module txuart_arbiter #(
    parameter int NREQ       = 4,
    parameter int GAP_CYCLES = 16,
    parameter int MAX_HOLD   = 1024
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic [NREQ-1:0]     i_req,
    input  logic [NREQ-1:0]     i_stb,
    input  logic [8*NREQ-1:0]   i_data,
    input  logic [NREQ-1:0]     i_last,
    output logic [NREQ-1:0]     o_busy,
    output logic [NREQ-1:0]     o_grant,
    output logic                o_tx_stb,
    output logic [7:0]          o_tx_data,
    input  logic                i_tx_busy
);

    localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_grant = 2'd1;
    localparam logic [1:0] c_drain = 2'd2;
    localparam logic [1:0] c_gap   = 2'd3;

    localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(MAX_HOLD - 1);
    localparam logic [GAP_W-1:0]  c_gap_load  = GAP_W'(GAP_CYCLES);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [PTR_W-1:0]  r_owner;
    logic [PTR_W-1:0]  r_rr_ptr;
    logic [PTR_W-1:0]  w_win_idx;
    logic              w_win_found;
    logic [HOLD_W-1:0] r_hold;
    logic [GAP_W-1:0]  r_gap;
    logic              w_accept;

    function automatic logic [PTR_W-1:0] f_wrap(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return s[PTR_W-1:0];
    endfunction

    assign w_accept = (r_state == c_grant) && i_stb[r_owner] && !i_tx_busy;

    // Scan downward so the smallest offset from the pointer is written last and wins.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_req[f_wrap(r_rr_ptr, i)]) begin
                w_win_found = 1'b1;
                w_win_idx   = f_wrap(r_rr_ptr, i);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= c_idle;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_hold   <= '0;
            r_gap    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_idle && w_win_found) begin
                r_owner  <= w_win_idx;
                r_rr_ptr <= f_wrap(w_win_idx, 1);
            end
            if (r_state != c_grant || w_accept)
                r_hold <= '0;
            else if (r_hold != c_hold_last)
                r_hold <= r_hold + HOLD_W'(1);
            if (r_state == c_drain)
                r_gap <= c_gap_load;
            else if (r_state == c_gap && r_gap != '0)
                r_gap <= r_gap - GAP_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (w_win_found) w_state_nxt = c_grant;
            c_grant: begin
                // An accept always beats abandon and watchdog in the same clock.
                if (w_accept) begin
                    if (i_last[r_owner]) w_state_nxt = c_drain;
                end else if (!i_req[r_owner] || r_hold == c_hold_last) begin
                    w_state_nxt = c_drain;
                end
            end
            c_drain: if (!i_tx_busy) w_state_nxt = (GAP_CYCLES > 0) ? c_gap : c_idle;
            c_gap:   if (r_gap <= GAP_W'(1)) w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    always_comb begin
        o_grant   = '0;
        o_tx_stb  = 1'b0;
        o_tx_data = '0;
        o_busy    = '1;
        if (r_state == c_grant) begin
            o_grant[r_owner] = 1'b1;
            o_tx_stb         = i_stb[r_owner];
            o_tx_data        = i_data[8*r_owner +: 8];
            o_busy[r_owner]  = i_tx_busy;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_txuart_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_txuart_arbiter
// Purpose : self-checking bench for txuart_arbiter with a txuart busy model.
// Revision: 1.0  initial release
// ============================================================================
module tb_txuart_arbiter;

    localparam int NREQ = 4;
    localparam int GAP  = 16;
    localparam int MAXH = 1024;
    localparam int ULEN = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req, stb, last, busy, grant;
    logic [8*NREQ-1:0] data;
    logic              tx_stb, tx_busy;
    logic [7:0]        tx_data;
    logic              manual = 1'b0;
    logic              man_busy = 1'b0;
    int                uart_cnt = 0;

    always #5 clk = ~clk;

    // txuart: busy rises the clock after an accept and stays for ULEN clocks.
    assign tx_busy = manual ? man_busy : (uart_cnt != 0);
    always @(posedge clk) begin
        if (tx_stb && !tx_busy) uart_cnt <= ULEN;
        else if (uart_cnt != 0) uart_cnt <= uart_cnt - 1;
    end

    txuart_arbiter #(.NREQ(NREQ), .GAP_CYCLES(GAP), .MAX_HOLD(MAXH)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_req(req), .i_stb(stb), .i_data(data),
        .i_last(last), .o_busy(busy), .o_grant(grant), .o_tx_stb(tx_stb),
        .o_tx_data(tx_data), .i_tx_busy(tx_busy)
    );

    typedef struct { logic [NREQ-1:0] g; logic [7:0] d; } exp_t;
    typedef struct {
        logic [3:0] stb; logic bsy; logic [7:0] d;
        logic ex_stb; logic [7:0] ex_d; logic [3:0] ex_busy;
    } vec_t;

    exp_t       exp_q[$];
    vec_t       vt[6];
    int         checks = 0, failures = 0;
    int         cyc = 0, last_acc_cyc = 0;
    int         src_msgs[NREQ], src_len[NREQ], src_left[NREQ], src_sent[NREQ], src_drop[NREQ];
    logic [7:0] src_byte[NREQ];
    logic [NREQ-1:0] src_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic setup_src(input int k, input int msgs, input int len, input logic [7:0] first);
        src_msgs[k] = msgs; src_len[k] = len; src_left[k] = len;
        src_byte[k] = first; src_sent[k] = 0; src_drop[k] = 0; src_stall[k] = 1'b0;
    endtask

    task automatic push_msg(input int k, input logic [7:0] first, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.g = NREQ'(1) << k;
            e.d = first + 8'(i);
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_sources();
        if (manual) return;
        for (int k = 0; k < NREQ; k++) begin
            req[k]       = (src_msgs[k] > 0);
            stb[k]       = (src_msgs[k] > 0) && !src_stall[k];
            last[k]      = (src_left[k] == 1);
            data[8*k +: 8] = src_byte[k];
        end
    endtask

    task automatic advance(input int k);
        src_byte[k] = src_byte[k] + 8'd1;
        src_sent[k]++;
        if (src_drop[k] != 0 && src_sent[k] == src_drop[k]) src_msgs[k] = 0;
        else if (src_left[k] == 1) begin src_msgs[k]--; src_left[k] = src_len[k]; end
        else src_left[k]--;
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int k = 0; k < NREQ; k++) if (src_msgs[k] > 0) p = 1'b1;
        return p;
    endfunction

    // One clock: check any accepted byte against the scoreboard, then drive.
    task automatic step();
        logic acc;
        logic [NREQ-1:0] g;
        exp_t e;
        @(negedge clk);
        acc = tx_stb && !tx_busy && !manual;
        g   = grant;
        checks++;
        if (!$onehot0(grant) || (tx_stb && grant == '0)) begin
            failures++;
            $display("FAIL grant_onehot: grant=%b tx_stb=%b required one-hot owner", grant, tx_stb);
        end
        if (acc) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: grant=%b data=%h, required no byte", g, tx_data);
            end else begin
                e = exp_q.pop_front();
                if (g !== e.g || tx_data !== e.d) begin
                    failures++;
                    $display("FAIL sb_byte: grant=%b data=%h, required grant=%b data=%h", g, tx_data, e.g, e.d);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (acc) begin
            last_acc_cyc = cyc;
            for (int k = 0; k < NREQ; k++) if (g[k]) advance(k);
        end
        drive_sources();
    endtask

    task automatic run_until_done(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || pending()) && n < budget) begin step(); n++; end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s_timeout: %0d bytes outstanding, required 0", name, exp_q.size());
        end
        repeat (ULEN + GAP + 4) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int acc_cyc;
        for (int k = 0; k < NREQ; k++) setup_src(k, 0, 1, 8'h00);
        drive_sources();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_tx_stb", tx_stb, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 4'b1111);

        // 1: three bytes from requester 0, then gap timing measured via requester 1
        rst_n = 1'b1;
        setup_src(0, 1, 3, 8'h41); push_msg(0, 8'h41, 3); drive_sources();
        #1 chk("t1_grant_before", grant, 0);
        step();
        #1 chk("t1_grant_after", grant, 4'b0001);
        n = 0;
        while (src_msgs[0] != 0 && n < 50) begin step(); n++; end
        acc_cyc = last_acc_cyc;
        setup_src(1, 1, 1, 8'h51); push_msg(1, 8'h51, 1); drive_sources();
        n = 0;
        while (grant == '0 && n < 100) begin step(); n++; end
        // drain: ULEN busy clocks + 1 seeing idle; then GAP clocks; then 1 IDLE clock
        chk("t1_gap_latency", cyc - acc_cyc, ULEN + 2 + GAP);
        chk("t1_next_owner", grant, 4'b0010);
        run_until_done("t1", 200);

        // 2: requesters 0 and 1 together straight out of reset
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        setup_src(0, 1, 2, 8'h10); setup_src(1, 1, 2, 8'h20);
        push_msg(0, 8'h10, 2); push_msg(1, 8'h20, 2);
        drive_sources();
        run_until_done("t2", 300);

        // 3: requesters 3 and 1 held for four messages; pointer left at 2
        setup_src(3, 2, 2, 8'h30); setup_src(1, 2, 2, 8'h60);
        push_msg(3, 8'h30, 2); push_msg(1, 8'h60, 2);
        push_msg(3, 8'h32, 2); push_msg(1, 8'h62, 2);
        drive_sources();
        run_until_done("t3", 600);

        // 4: requester 2 abandons after one byte, requester 0 follows
        setup_src(2, 1, 3, 8'h70); src_drop[2] = 1;
        setup_src(0, 1, 2, 8'h80);
        push_msg(2, 8'h70, 1); push_msg(0, 8'h80, 2);
        drive_sources();
        n = 0;
        while (src_sent[2] == 0 && n < 50) begin step(); n++; end
        chk("t4_owner_before_drop", grant, 4'b0100);
        step();
        #1 chk("t4_abandon_grant", grant, 0);
        run_until_done("t4", 300);

        // table: combinational muxing while requester 0 owns the grant
        vt[0] = '{4'b0000, 1'b0, 8'h11, 1'b0, 8'h11, 4'b1110};
        vt[1] = '{4'b0001, 1'b0, 8'h5A, 1'b1, 8'h5A, 4'b1110};
        vt[2] = '{4'b0001, 1'b1, 8'hA5, 1'b1, 8'hA5, 4'b1111};
        vt[3] = '{4'b1110, 1'b0, 8'h33, 1'b0, 8'h33, 4'b1110};
        vt[4] = '{4'b1111, 1'b1, 8'hC3, 1'b1, 8'hC3, 4'b1111};
        vt[5] = '{4'b0000, 1'b1, 8'h7E, 1'b0, 8'h7E, 4'b1111};
        manual = 1'b1; man_busy = 1'b0;
        req = 4'b0001; stb = '0; last = '0; data = {8'hEE, 8'hEE, 8'hEE, 8'h00};
        step();
        #1 chk("tv_grant", grant, 4'b0001);
        for (int i = 0; i < 6; i++) begin
            stb = vt[i].stb; man_busy = vt[i].bsy; data[7:0] = vt[i].d;
            #1;
            chk($sformatf("tv%0d_tx_stb", i), tx_stb, vt[i].ex_stb);
            chk($sformatf("tv%0d_tx_data", i), tx_data, vt[i].ex_d);
            chk($sformatf("tv%0d_busy", i), busy, vt[i].ex_busy);
            chk($sformatf("tv%0d_grant", i), grant, 4'b0001);
            @(posedge clk); #1;
        end
        req = '0; stb = '0; man_busy = 1'b0;
        @(posedge clk); #1;
        chk("tv_release_grant", grant, 0);
        chk("tv_release_busy", busy, 4'b1111);
        manual = 1'b0;
        drive_sources();
        repeat (ULEN + GAP + 4) step();

        // 5: watchdog releases a silent owner after exactly MAX_HOLD clocks
        setup_src(0, 1, 1, 8'h99); src_stall[0] = 1'b1; drive_sources();
        n = 0;
        while (grant[0] == 1'b0 && n < 100) begin step(); n++; end
        n = 0;
        while (grant[0] == 1'b1 && n < 2 * MAXH) begin n++; step(); end
        chk("t5_hold_clocks", n, MAXH);
        chk("t5_busy_after", busy[0], 1);
        src_msgs[0] = 0; drive_sources();
        repeat (ULEN + GAP + 4) step();
        chk("t5_no_regrant", grant, 0);

        // 6: reset while txuart is mid-byte
        setup_src(0, 1, 2, 8'hC0); push_msg(0, 8'hC0, 2); drive_sources();
        n = 0;
        while (src_sent[0] == 0 && n < 50) begin step(); n++; end
        #1 chk("t6_stb_before", tx_stb, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_stb", tx_stb, 0);
        chk("t6_rst_grant", grant, 0);
        chk("t6_rst_busy", busy, 4'b1111);
        step();
        rst_n = 1'b1;
        step();
        #1;
        chk("t6_regrant", grant, 4'b0001);
        chk("t6_busy_while_tx", busy[0], 1);
        run_until_done("t6", 200);

        chk("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
